// File: rtl/ysyx_22040127_regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Sits between ID (read, allocate) and WB (write, busy clear).
module ysyx_22040127_regfile_mp #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NR         = 2,
    parameter int NW         = 2,
    parameter int BYPASS     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NR*ADDR_WIDTH-1:0]   raddr,
    output logic [NR*DATA_WIDTH-1:0]   rdata,
    output logic [NR-1:0]              rbusy,
    input  logic [NW-1:0]              wen,
    input  logic [NW*ADDR_WIDTH-1:0]   waddr,
    input  logic [NW*DATA_WIDTH-1:0]   wdata,
    input  logic [NW-1:0]              wclr,
    input  logic                       alloc_valid,
    input  logic [ADDR_WIDTH-1:0]      alloc_addr,
    output logic                       alloc_ready,
    output logic [(1<<ADDR_WIDTH)-1:0] busy_vec
);

    localparam int NREG = 1 << ADDR_WIDTH;
    localparam bit BYP  = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_nxt;
    logic [NREG-1:0]       clr_hit;

    // Registers retired by a same-cycle write with clear; x0 never counts
    always_comb begin
        clr_hit = '0;
        for (int j = 0; j < NW; j++) begin
            if (wen[j] && wclr[j]) begin
                clr_hit[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end
        end
        clr_hit[0] = 1'b0;
    end

    // WAW refused while busy unless the producer retires this cycle
    assign alloc_ready = ~busy[alloc_addr] | clr_hit[alloc_addr];
    assign busy_vec    = busy;

    // Scoreboard next state: allocation beats clear, clear beats hold
    always_comb begin
        busy_nxt = busy & ~clr_hit;
        if (alloc_valid && alloc_ready && (alloc_addr != '0)) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Register array write; later ports override earlier ones on collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                    regs[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <=
                        wdata[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Read ports: array lookup, optional forwarding, retire-aware busy
    always_comb begin : rd_mux
        logic [ADDR_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0] d;
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NR; i++) begin
            idx = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            d   = regs[idx];
            if (BYP && (idx != '0)) begin
                for (int j = 0; j < NW; j++) begin
                    if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == idx)) begin
                        d = wdata[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            if (idx == '0) begin
                d = '0;
            end
            rdata[i*DATA_WIDTH +: DATA_WIDTH] = d;
            rbusy[i] = busy[idx] & ~(BYP & clr_hit[idx]);
        end
    end

endmodule

// File: tb/tb_ysyx_22040127_regfile_mp.sv
// Bench for ysyx_22040127_regfile_mp: directed table plus random traffic
// checked against a behavioural model, with BYPASS=1 and BYPASS=0 copies.
module tb_ysyx_22040127_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   raddr;
    logic [1:0]   wen;
    logic [9:0]   waddr;
    logic [127:0] wdata;
    logic [1:0]   wclr;
    logic         alloc_valid;
    logic [4:0]   alloc_addr;

    logic [127:0] rdata_1, rdata_0;
    logic [1:0]   rbusy_1, rbusy_0;
    logic         ready_1, ready_0;
    logic [31:0]  bv_1, bv_0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_reg [32];
    bit   [31:0] m_busy;

    always #5 clk = ~clk;

    ysyx_22040127_regfile_mp #(.BYPASS(1)) u_b1 (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_1),
        .rbusy(rbusy_1), .wen(wen), .waddr(waddr), .wdata(wdata),
        .wclr(wclr), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .alloc_ready(ready_1), .busy_vec(bv_1)
    );

    ysyx_22040127_regfile_mp #(.BYPASS(0)) u_b0 (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_0),
        .rbusy(rbusy_0), .wen(wen), .waddr(waddr), .wdata(wdata),
        .wclr(wclr), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .alloc_ready(ready_0), .busy_vec(bv_0)
    );

    typedef struct {
        bit        rst;
        bit [1:0]  wen;
        bit [1:0]  wclr;
        bit [4:0]  wa0, wa1;
        bit [63:0] wd0, wd1;
        bit [4:0]  ra0;
        bit        av;
        bit [4:0]  aa;
        bit [63:0] e_rd_b1, e_rd_b0;
        bit        e_rb_b1, e_rb_b0;
        bit        e_rdy;
        bit [31:0] e_bv;
    } vec_t;

    vec_t tv [19];

    function automatic vec_t mkv(
        bit r, bit [1:0] we, bit [1:0] wc, bit [4:0] a0, bit [4:0] a1,
        bit [63:0] d0, bit [63:0] d1, bit [4:0] ra, bit av, bit [4:0] aa,
        bit [63:0] e1, bit [63:0] e0, bit b1, bit b0, bit rdy,
        bit [31:0] bv);
        vec_t v;
        v.rst = r; v.wen = we; v.wclr = wc; v.wa0 = a0; v.wa1 = a1;
        v.wd0 = d0; v.wd1 = d1; v.ra0 = ra; v.av = av; v.aa = aa;
        v.e_rd_b1 = e1; v.e_rd_b0 = e0; v.e_rb_b1 = b1; v.e_rb_b0 = b0;
        v.e_rdy = rdy; v.e_bv = bv;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] wa(int j);
        return waddr[j*5 +: 5];
    endfunction

    function automatic bit clear_hit(logic [4:0] a);
        bit h = 0;
        for (int j = 0; j < 2; j++)
            if (a != 0 && wen[j] && wclr[j] && wa(j) == a) h = 1;
        return h;
    endfunction

    function automatic logic [63:0] m_read(bit byp, logic [4:0] a);
        logic [63:0] d;
        if (a == 0) return 64'h0;
        d = m_reg[a];
        if (byp)
            for (int j = 0; j < 2; j++)
                if (wen[j] && wa(j) == a) d = wdata[j*64 +: 64];
        return d;
    endfunction

    function automatic bit m_rbusy(bit byp, logic [4:0] a);
        return m_busy[a] && !(byp && clear_hit(a));
    endfunction

    function automatic bit m_ready();
        return !m_busy[alloc_addr] || clear_hit(alloc_addr);
    endfunction

    task automatic model_update();
        bit [31:0] nb;
        bit acc;
        if (rst) begin
            for (int r = 0; r < 32; r++) m_reg[r] = '0;
            m_busy = '0;
        end else begin
            acc = alloc_valid && m_ready();
            nb = '0;
            for (int r = 1; r < 32; r++) begin
                if (acc && alloc_addr == r) nb[r] = 1;
                else if (clear_hit(5'(r))) nb[r] = 0;
                else nb[r] = m_busy[r];
            end
            for (int j = 0; j < 2; j++)
                if (wen[j] && wa(j) != 0) m_reg[wa(j)] = wdata[j*64 +: 64];
            m_busy = nb;
        end
    endtask

    task automatic model_check_and_clock();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m_rdata%0d_b1", i), rdata_1[i*64 +: 64],
                m_read(1, raddr[i*5 +: 5]));
            chk($sformatf("m_rdata%0d_b0", i), rdata_0[i*64 +: 64],
                m_read(0, raddr[i*5 +: 5]));
            chk($sformatf("m_rbusy%0d_b1", i), 64'(rbusy_1[i]),
                64'(m_rbusy(1, raddr[i*5 +: 5])));
            chk($sformatf("m_rbusy%0d_b0", i), 64'(rbusy_0[i]),
                64'(m_rbusy(0, raddr[i*5 +: 5])));
        end
        chk("m_ready_b1", 64'(ready_1), 64'(m_ready()));
        chk("m_ready_b0", 64'(ready_0), 64'(m_ready()));
        chk("m_busyvec_b1", 64'(bv_1), 64'(m_busy));
        chk("m_busyvec_b0", 64'(bv_0), 64'(m_busy));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; wen = 0; wclr = 0; waddr = 0; wdata = 0;
        raddr = 0; alloc_valid = 0; alloc_addr = 0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) m_reg[r] = '0;
        m_busy = '0;

        tv[0]  = mkv(1, 2'b11, 0, 3, 3, 64'hbad0, 64'hbad1, 0, 0, 0,
                     0, 0, 0, 0, 1, 0);
        tv[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0);
        tv[2]  = mkv(0, 2'b11, 0, 5, 5, 64'h11, 64'h22, 5, 0, 0,
                     64'h22, 0, 0, 0, 1, 0);
        tv[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 5, 0, 0,
                     64'h22, 64'h22, 0, 0, 1, 0);
        tv[4]  = mkv(0, 2'b01, 0, 0, 0, 64'hdead, 0, 0, 1, 0,
                     0, 0, 0, 0, 1, 0);
        tv[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tv[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 7, 1, 7, 0, 0, 0, 0, 1, 0);
        tv[7]  = mkv(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 1,
                     32'h80);
        tv[8]  = mkv(0, 2'b01, 2'b01, 7, 0, 64'h99, 0, 7, 0, 0,
                     64'h99, 0, 0, 1, 1, 32'h80);
        tv[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 7, 0, 0,
                     64'h99, 64'h99, 0, 0, 1, 0);
        tv[10] = mkv(0, 0, 0, 0, 0, 0, 0, 9, 1, 9, 0, 0, 0, 0, 1, 0);
        tv[11] = mkv(0, 0, 0, 0, 0, 0, 0, 9, 1, 9, 0, 0, 1, 1, 0,
                     32'h200);
        tv[12] = mkv(0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 1, 1, 1,
                     32'h200);
        tv[13] = mkv(0, 2'b10, 2'b10, 0, 9, 0, 64'h77, 9, 1, 9,
                     64'h77, 0, 0, 1, 1, 32'h200);
        tv[14] = mkv(0, 0, 0, 0, 0, 0, 0, 9, 0, 0,
                     64'h77, 64'h77, 1, 1, 1, 32'h200);
        tv[15] = mkv(0, 2'b01, 0, 4, 0, 64'h5, 0, 4, 1, 4,
                     64'h5, 0, 0, 0, 1, 32'h200);
        tv[16] = mkv(1, 2'b01, 0, 4, 0, 64'h123, 0, 4, 1, 6,
                     64'h123, 64'h5, 1, 1, 1, 32'h210);
        tv[17] = mkv(0, 0, 0, 0, 0, 0, 0, 4, 0, 6, 0, 0, 0, 0, 1, 0);
        tv[18] = mkv(0, 0, 0, 0, 0, 0, 0, 6, 0, 6, 0, 0, 0, 0, 1, 0);

        idle_inputs();
        rst = 1;
        @(posedge clk);
        model_update();
        #1;

        for (int k = 0; k < 19; k++) begin
            rst = tv[k].rst; wen = tv[k].wen; wclr = tv[k].wclr;
            waddr = {tv[k].wa1, tv[k].wa0};
            wdata = {tv[k].wd1, tv[k].wd0};
            raddr = {5'd5, tv[k].ra0};
            alloc_valid = tv[k].av; alloc_addr = tv[k].aa;
            #3;
            chk($sformatf("t%0d_rdata_b1", k), rdata_1[63:0], tv[k].e_rd_b1);
            chk($sformatf("t%0d_rdata_b0", k), rdata_0[63:0], tv[k].e_rd_b0);
            chk($sformatf("t%0d_rbusy_b1", k), 64'(rbusy_1[0]),
                64'(tv[k].e_rb_b1));
            chk($sformatf("t%0d_rbusy_b0", k), 64'(rbusy_0[0]),
                64'(tv[k].e_rb_b0));
            chk($sformatf("t%0d_ready", k), 64'(ready_1), 64'(tv[k].e_rdy));
            chk($sformatf("t%0d_busyvec", k), 64'(bv_1), 64'(tv[k].e_bv));
            model_check_and_clock();
        end

        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            wen = 2'($urandom);
            wclr = 2'($urandom);
            waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wdata = {$urandom, $urandom, $urandom, $urandom};
            raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            alloc_valid = 1'($urandom);
            alloc_addr = 5'($urandom_range(0, 7));
            #3;
            model_check_and_clock();
        end

        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
